// File: rtl/sort_pkg.sv
// Shared types for the sort block's output-side checker: FSM states, error-bit
// positions and the per-packet result record.
package sort_pkg;

   localparam int PKG_DATA_WIDTH = 16;
   localparam int PKG_MAX_LENGTH = 128;
   localparam int PKG_LEN_WIDTH  = $clog2(PKG_MAX_LENGTH + 2);
   localparam int PKG_SUM_WIDTH  = PKG_DATA_WIDTH + PKG_LEN_WIDTH;

   localparam int ERR_ORDER   = 0;
   localparam int ERR_LENGTH  = 1;
   localparam int ERR_FRAMING = 2;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      IN_PKT = 1'b1
   } state_t;

   // "xor" is a keyword, so the xor field is named xor_val
   typedef struct packed {
      logic [2:0]                err;
      logic [PKG_LEN_WIDTH-1:0]  len;
      logic [PKG_LEN_WIDTH-1:0]  first_bad;
      logic [PKG_SUM_WIDTH-1:0]  sum;
      logic [PKG_DATA_WIDTH-1:0] xor_val;
   } res_t;

endpackage

// File: rtl/sort_out_checker.sv
// Passive checker on the sort block's output stream: framing, length bounds,
// non-decreasing order, per-packet sum/xor and running status counters.
module sort_out_checker
   import sort_pkg::*;
#(
   parameter int DATA_WIDTH = PKG_DATA_WIDTH,
   parameter int MAX_LENGTH = PKG_MAX_LENGTH,
   parameter int MIN_LENGTH = 2,
   parameter int CNT_WIDTH  = 32,
   localparam int LW = $clog2(MAX_LENGTH + 2)
) (
   input  logic                     src_clock,
   input  logic                     src_reset_n,
   input  logic                     snk_valid,
   input  logic                     snk_sop,
   input  logic                     snk_eop,
   input  logic [DATA_WIDTH-1:0]    snk_data,
   output logic                     res_valid,
   output logic                     res_ok,
   output logic [2:0]               res_err,
   output logic [LW-1:0]            res_len,
   output logic [LW-1:0]            res_first_bad,
   output logic [DATA_WIDTH+LW-1:0] res_sum,
   output logic [DATA_WIDTH-1:0]    res_xor,
   output logic [CNT_WIDTH-1:0]     pkt_cnt,
   output logic [CNT_WIDTH-1:0]     err_cnt,
   output logic [CNT_WIDTH-1:0]     orphan_cnt
);

   localparam int SW = DATA_WIDTH + LW;
   localparam logic [LW-1:0] LEN_SAT = LW'(MAX_LENGTH + 1);

   function automatic logic len_bad(input logic [LW-1:0] len);
      return (int'(len) < MIN_LENGTH) || (int'(len) > MAX_LENGTH);
   endfunction

   // Reset asserts asynchronously but is released on a clock edge.
   logic [1:0] rst_sync_reg;
   logic       rst_n;

   always_ff @(posedge src_clock or negedge src_reset_n) begin
      if (!src_reset_n) rst_sync_reg <= 2'b00;
      else              rst_sync_reg <= {rst_sync_reg[0], 1'b1};
   end
   assign rst_n = rst_sync_reg[1];

   state_t                state_reg;
   logic [LW-1:0]         len_reg, first_bad_reg;
   logic [DATA_WIDTH-1:0] prev_reg, xor_reg;
   logic [SW-1:0]         sum_reg;
   logic                  order_reg;

   logic                  sop_beat, eop_beat, in_pkt;
   logic [SW-1:0]         data_ext, sum_inc;
   logic [LW-1:0]         len_inc, first_bad_inc;
   logic [DATA_WIDTH-1:0] xor_inc;
   logic                  order_viol, order_inc;

   assign sop_beat      = snk_valid & snk_sop;
   assign eop_beat      = snk_valid & snk_eop;
   assign in_pkt        = (state_reg == IN_PKT);
   assign data_ext      = SW'(snk_data);
   assign len_inc       = (len_reg == LEN_SAT) ? len_reg : len_reg + 1'b1;
   assign sum_inc       = sum_reg + data_ext;
   assign xor_inc       = xor_reg ^ snk_data;
   assign order_viol    = snk_data < prev_reg;
   assign order_inc     = order_reg | order_viol;
   assign first_bad_inc = (!order_reg && order_viol) ? len_reg : first_bad_reg;

   always_ff @(posedge src_clock or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         len_reg       <= '0;
         first_bad_reg <= '0;
         prev_reg      <= '0;
         xor_reg       <= '0;
         sum_reg       <= '0;
         order_reg     <= 1'b0;
      end else if (sop_beat && !eop_beat) begin
         state_reg     <= IN_PKT;
         len_reg       <= LW'(1);
         first_bad_reg <= '0;
         prev_reg      <= snk_data;
         xor_reg       <= snk_data;
         sum_reg       <= data_ext;
         order_reg     <= 1'b0;
      end else if (sop_beat) begin
         state_reg     <= IDLE;
      end else if (in_pkt && snk_valid) begin
         if (snk_eop) begin
            state_reg     <= IDLE;
         end else begin
            len_reg       <= len_inc;
            first_bad_reg <= first_bad_inc;
            prev_reg      <= snk_data;
            xor_reg       <= xor_inc;
            sum_reg       <= sum_inc;
            order_reg     <= order_inc;
         end
      end
   end

   // rep_a closes the packet in progress; rep_b is a single sop&eop beat.
   res_t rep_a, rep_b, out_res, skid_next, skid_reg, res_reg;
   logic rep_a_valid, rep_b_valid, out_valid, skid_next_valid, skid_valid_reg;
   logic res_valid_reg, res_ok_reg;

   always_comb begin
      rep_a       = '0;
      rep_a_valid = in_pkt && snk_valid && (snk_sop || snk_eop);
      if (snk_sop) begin
         rep_a.err[ERR_FRAMING] = 1'b1;
         rep_a.err[ERR_LENGTH]  = len_bad(len_reg);
         rep_a.err[ERR_ORDER]   = order_reg;
         rep_a.len              = len_reg;
         rep_a.first_bad        = first_bad_reg;
         rep_a.sum              = sum_reg;
         rep_a.xor_val          = xor_reg;
      end else begin
         rep_a.err[ERR_LENGTH]  = len_bad(len_inc);
         rep_a.err[ERR_ORDER]   = order_inc;
         rep_a.len              = len_inc;
         rep_a.first_bad        = first_bad_inc;
         rep_a.sum              = sum_inc;
         rep_a.xor_val          = xor_inc;
      end

      rep_b                  = '0;
      rep_b_valid            = sop_beat && eop_beat;
      rep_b.err[ERR_LENGTH]  = len_bad(LW'(1));
      rep_b.len              = LW'(1);
      rep_b.sum              = data_ext;
      rep_b.xor_val          = snk_data;

      // Oldest report goes out first; at most one is ever left over.
      out_valid       = 1'b0;
      out_res         = '0;
      skid_next_valid = 1'b0;
      skid_next       = '0;
      if (skid_valid_reg) begin
         out_valid       = 1'b1;
         out_res         = skid_reg;
         skid_next_valid = rep_a_valid || rep_b_valid;
         skid_next       = rep_a_valid ? rep_a : rep_b;
      end else if (rep_a_valid) begin
         out_valid       = 1'b1;
         out_res         = rep_a;
         skid_next_valid = rep_b_valid;
         skid_next       = rep_b;
      end else if (rep_b_valid) begin
         out_valid       = 1'b1;
         out_res         = rep_b;
      end
   end

   always_ff @(posedge src_clock or negedge rst_n) begin
      if (!rst_n) begin
         skid_valid_reg <= 1'b0;
         skid_reg       <= '0;
         res_valid_reg  <= 1'b0;
         res_ok_reg     <= 1'b0;
         res_reg        <= '0;
         pkt_cnt        <= '0;
         err_cnt        <= '0;
         orphan_cnt     <= '0;
      end else begin
         skid_valid_reg <= skid_next_valid;
         skid_reg       <= skid_next;
         res_valid_reg  <= out_valid;
         if (out_valid) begin
            res_reg    <= out_res;
            res_ok_reg <= (out_res.err == 3'b000);
            if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + 1'b1;
            if (out_res.err != 3'b000 && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
         end
         if (!in_pkt && snk_valid && !snk_sop && orphan_cnt != '1)
            orphan_cnt <= orphan_cnt + 1'b1;
      end
   end

   assign res_valid     = res_valid_reg;
   assign res_ok        = res_ok_reg;
   assign res_err       = res_reg.err;
   assign res_len       = res_reg.len;
   assign res_first_bad = res_reg.first_bad;
   assign res_sum       = res_reg.sum;
   assign res_xor       = res_reg.xor_val;

endmodule

// File: tb/tb_sort_out_checker.sv
// Bench for sort_out_checker: directed scenarios plus a randomized run, checked
// against a packet-level reference model with a report scoreboard.
module tb_sort_out_checker;

   localparam int DW   = 16;
   localparam int MAXL = 128;
   localparam int LW   = 8;
   localparam int SW   = DW + LW;
   localparam int CW   = 32;

   logic          src_clock = 1'b0;
   logic          src_reset_n = 1'b1;
   logic          snk_valid = 1'b0, snk_sop = 1'b0, snk_eop = 1'b0;
   logic [DW-1:0] snk_data = '0;
   logic          res_valid, res_ok;
   logic [2:0]    res_err;
   logic [LW-1:0] res_len, res_first_bad;
   logic [SW-1:0] res_sum;
   logic [DW-1:0] res_xor;
   logic [CW-1:0] pkt_cnt, err_cnt, orphan_cnt;

   sort_out_checker dut (
      .src_clock(src_clock), .src_reset_n(src_reset_n),
      .snk_valid(snk_valid), .snk_sop(snk_sop), .snk_eop(snk_eop), .snk_data(snk_data),
      .res_valid(res_valid), .res_ok(res_ok), .res_err(res_err), .res_len(res_len),
      .res_first_bad(res_first_bad), .res_sum(res_sum), .res_xor(res_xor),
      .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .orphan_cnt(orphan_cnt)
   );

   always #5 src_clock = ~src_clock;

   typedef struct packed {
      logic [31:0]   cyc;
      logic [2:0]    err;
      logic          ok;
      logic [LW-1:0] len;
      logic [LW-1:0] fb;
      logic [SW-1:0] sum;
      logic [DW-1:0] xr;
   } rep_t;

   int   n_tests = 0, n_fail = 0;
   int   cyc = 0;
   rep_t obs_q[$], exp_q[$];

   always @(posedge src_clock) begin
      rep_t r;
      cyc++;
      #1;
      if (res_valid === 1'b1) begin
         r.cyc = cyc; r.err = res_err; r.ok = res_ok; r.len = res_len;
         r.fb = res_first_bad; r.sum = res_sum; r.xr = res_xor;
         obs_q.push_back(r);
      end
   end

   // Reference model: beats of the open packet kept in a list, report built at close.
   logic [DW-1:0] cur[$];
   bit            in_pkt = 0;
   int            last_tgt = 0;
   int            exp_pkt = 0, exp_err = 0, exp_orphan = 0;

   task automatic model_close(input bit framing, input int smp);
      rep_t   r;
      int     n = cur.size();
      longint s = 0;
      logic [DW-1:0] x = '0;
      int     fb = 0;
      bit     ord = 0;
      foreach (cur[i]) begin
         s += longint'(cur[i]);
         x ^= cur[i];
         if (i > 0 && !ord && cur[i] < cur[i-1]) begin ord = 1; fb = i; end
      end
      r.err = {framing, (n < 2 || n > MAXL), ord};
      r.ok  = (r.err == 3'b000);
      r.len = LW'((n > MAXL) ? MAXL + 1 : n);
      r.fb  = LW'(fb);
      r.sum = s[SW-1:0];
      r.xr  = x;
      r.cyc = (smp > last_tgt) ? smp : last_tgt + 1;
      last_tgt = r.cyc;
      exp_q.push_back(r);
      exp_pkt++;
      if (!r.ok) exp_err++;
   endtask

   task automatic model_beat(input bit v, s, e, input logic [DW-1:0] d, input int smp);
      if (!v) return;
      if (s) begin
         if (in_pkt) model_close(1'b1, smp);
         cur.delete(); cur.push_back(d); in_pkt = 1;
         if (e) begin model_close(1'b0, smp); in_pkt = 0; end
      end else if (!in_pkt) begin
         exp_orphan++;
      end else begin
         cur.push_back(d);
         if (e) begin model_close(1'b0, smp); in_pkt = 0; end
      end
   endtask

   task automatic drive(input bit v, s, e, input logic [DW-1:0] d);
      @(negedge src_clock);
      snk_valid = v; snk_sop = s; snk_eop = e; snk_data = d;
      model_beat(v, s, e, d, cyc + 1);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic assert_reset();
      @(negedge src_clock);
      src_reset_n = 1'b0;
      snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0; snk_data = '0;
      cur.delete(); in_pkt = 0; exp_q.delete(); obs_q.delete();
      exp_pkt = 0; exp_err = 0; exp_orphan = 0; last_tgt = 0;
   endtask

   task automatic release_reset();
      @(negedge src_clock);
      src_reset_n = 1'b1;
      repeat (3) @(negedge src_clock);
   endtask

   task automatic test_reset();
      #2 src_reset_n = 1'b0;
      repeat (2) @(negedge src_clock);
      n_tests++;
      if ({res_valid, res_ok, res_err, res_len, res_first_bad, res_sum, res_xor} !== '0) begin
         n_fail++; $display("FAIL reset_res: got valid=%b ok=%b err=%b len=%0d, want all 0", res_valid, res_ok, res_err, res_len);
      end
      n_tests++;
      if ({pkt_cnt, err_cnt, orphan_cnt} !== '0) begin
         n_fail++; $display("FAIL reset_cnt: got %0d/%0d/%0d, want 0/0/0", pkt_cnt, err_cnt, orphan_cnt);
      end
      release_reset();
   endtask

   task automatic test_sorted_packet();
      rep_t o, e;
      drive(1, 1, 0, 3); drive(1, 0, 0, 7); drive(1, 0, 0, 7); drive(1, 0, 0, 100); drive(1, 0, 1, 65535);
      idle(3);
      o = (obs_q.size() > 0) ? obs_q[0] : '0;
      n_tests++;
      if (o.len !== 8'd5 || o.sum !== 24'd65652 || o.ok !== 1'b1 || pkt_cnt !== 32'd1) begin
         n_fail++; $display("FAIL sorted_fields: got len=%0d sum=%0d ok=%b pkt=%0d, want 5 65652 1 1", o.len, o.sum, o.ok, pkt_cnt);
      end
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL sorted_count: got %0d reports, want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL sorted_report: got %h, want %h", o, e); end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_order();
      rep_t o, e;
      drive(1, 1, 0, 10); drive(1, 0, 0, 20); drive(1, 0, 0, 15); drive(1, 0, 1, 30);
      idle(3);
      o = (obs_q.size() > 0) ? obs_q[0] : '0;
      n_tests++;
      if (o.err !== 3'b001 || o.fb !== 8'd2 || o.ok !== 1'b0 || err_cnt !== 32'd1) begin
         n_fail++; $display("FAIL order_fields: got err=%b fb=%0d ok=%b errcnt=%0d, want 001 2 0 1", o.err, o.fb, o.ok, err_cnt);
      end
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL order_count: got %0d reports, want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL order_report: got %h, want %h", o, e); end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_length_sat();
      rep_t o, e;
      for (int i = 0; i < 130; i++) drive(1, i == 0, i == 129, DW'(i));
      idle(3);
      o = (obs_q.size() > 0) ? obs_q[0] : '0;
      n_tests++;
      if (o.len !== 8'd129 || o.err !== 3'b010 || o.sum !== 24'd8385) begin
         n_fail++; $display("FAIL length_fields: got len=%0d err=%b sum=%0d, want 129 010 8385", o.len, o.err, o.sum);
      end
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL length_count: got %0d reports, want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL length_report: got %h, want %h", o, e); end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_framing();
      rep_t o, e;
      drive(1, 0, 0, 5); drive(1, 1, 0, 1); drive(1, 0, 0, 2); drive(1, 1, 0, 3); drive(1, 0, 1, 4);
      idle(3);
      n_tests++;
      if (orphan_cnt !== 32'd1) begin n_fail++; $display("FAIL framing_orphan: got %0d, want 1", orphan_cnt); end
      n_tests++;
      if (obs_q.size() != 2 || obs_q[0].len !== 8'd2 || obs_q[0].err !== 3'b100 || obs_q[1].len !== 8'd2 || obs_q[1].ok !== 1'b1) begin
         n_fail++; $display("FAIL framing_fields: got %0d reports, want 2 (framed len 2, then clean len 2)", obs_q.size());
      end
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL framing_count: got %0d reports, want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL framing_report: got %h, want %h", o, e); end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_single_beat();
      rep_t o, e;
      drive(1, 1, 1, 9);
      idle(3);
      o = (obs_q.size() > 0) ? obs_q[0] : '0;
      n_tests++;
      if (o.len !== 8'd1 || o.err !== 3'b010) begin
         n_fail++; $display("FAIL single_fields: got len=%0d err=%b, want 1 010", o.len, o.err);
      end
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL single_count: got %0d reports, want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL single_report: got %h, want %h", o, e); end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   // sop&eop inside a packet yields two reports from one beat, then more closes follow.
   task automatic test_skid();
      rep_t o, e;
      drive(1, 1, 0, 1); drive(1, 1, 1, 2); drive(1, 1, 1, 3); drive(1, 1, 0, 4); drive(1, 0, 1, 5);
      idle(4);
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL skid_count: got %0d reports, want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL skid_report: got %h, want %h", o, e); end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_back_to_back();
      rep_t o, e;
      drive(1, 1, 0, 4); drive(1, 0, 1, 8); drive(1, 1, 0, 6); drive(1, 0, 0, 2); drive(1, 0, 1, 9);
      drive(1, 1, 0, 1); drive(1, 0, 1, 1);
      idle(3);
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d reports, want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL b2b_report: got %h, want %h", o, e); end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_random();
      rep_t o, e;
      for (int i = 0; i < 600; i++) begin
         bit v = ($urandom_range(0, 9) < 8);
         bit s = ($urandom_range(0, 99) < 15);
         bit t = ($urandom_range(0, 99) < 20);
         logic [DW-1:0] d = ($urandom_range(0, 1) == 1) ? DW'($urandom_range(0, 20)) : DW'($urandom);
         drive(v, s, t, d);
      end
      idle(4);
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random_count: got %0d reports, want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL random_report: got %h, want %h", o, e); end
      end
      obs_q.delete(); exp_q.delete();
      n_tests++;
      if (pkt_cnt !== CW'(exp_pkt) || err_cnt !== CW'(exp_err) || orphan_cnt !== CW'(exp_orphan)) begin
         n_fail++; $display("FAIL random_counters: got %0d/%0d/%0d, want %0d/%0d/%0d", pkt_cnt, err_cnt, orphan_cnt, exp_pkt, exp_err, exp_orphan);
      end
   endtask

   task automatic test_reset_mid_packet();
      rep_t o;
      drive(1, 1, 0, 11); drive(1, 0, 0, 12); drive(1, 0, 0, 13);
      assert_reset();
      #1;
      n_tests++;
      if ({res_valid, res_ok, res_err, res_len, res_first_bad, res_sum, res_xor, pkt_cnt, err_cnt, orphan_cnt} !== '0) begin
         n_fail++; $display("FAIL midreset_zero: got pkt=%0d err=%0d orphan=%0d len=%0d, want all 0", pkt_cnt, err_cnt, orphan_cnt, res_len);
      end
      release_reset();
      drive(1, 1, 0, 1); drive(1, 0, 1, 2);
      idle(3);
      o = (obs_q.size() > 0) ? obs_q[0] : '0;
      n_tests++;
      if (obs_q.size() != 1 || o.len !== 8'd2 || o.ok !== 1'b1 || pkt_cnt !== 32'd1) begin
         n_fail++; $display("FAIL midreset_after: got %0d reports len=%0d ok=%b pkt=%0d, want 1 2 1 1", obs_q.size(), o.len, o.ok, pkt_cnt);
      end
      n_tests++;
      if (exp_q.size() != 1 || o !== exp_q[0]) begin
         n_fail++; $display("FAIL midreset_report: got %h, want model report", o);
      end
      obs_q.delete(); exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_sorted_packet();
      test_order();
      test_length_sat();
      test_framing();
      test_single_beat();
      test_skid();
      test_back_to_back();
      test_random();
      test_reset_mid_packet();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
